axi_read_arbiter: RTL

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/axi_read_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter types and constants.
// Widths, burst encodings and FSM state type.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
// The requester not granted last wins a tie.
module rr_arbiter2
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       idx
);

  logic last;

  // pick a winner: lone requester, else the one not served last
  always_comb begin
    idx = 1'b0;
    gnt = 2'b00;
    if (req == 2'b11) idx = ~last;
    else              idx = req[1];
    if (|req) gnt = idx ? 2'b10 : 2'b01;
  end

  // remember who was served; reset favours s0 on the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last <= 1'b1;
    else if (en && |req) last <= idx;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter, one read outstanding.
// AR is registered; R is routed combinationally.
module axi_read_arbiter
  import axi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy,
  output logic              len_err
);

  arb_state_t       state, nxt;
  ar_t              ar_q;
  logic             gnt_q;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             gnt_idx;
  logic             arb_en;
  logic             r_hs;

  assign req    = {s1_arvalid, s0_arvalid};
  assign arb_en = (state == IDLE);
  assign r_hs   = (state == DATA) && rvalid && rready;

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;
  assign arburst = ar_q.burst;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign s0_rid   = rid;
  assign s0_rdata = rdata;
  assign s0_rresp = rresp;
  assign s0_rlast = rlast;
  assign s1_rid   = rid;
  assign s1_rdata = rdata;
  assign s1_rresp = rresp;
  assign s1_rlast = rlast;

  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state and handshake steering
  always_comb begin
    nxt        = state;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    unique case (state)
      IDLE: begin
        s0_arready = gnt[0];
        s1_arready = gnt[1];
        if (|req) nxt = ADDR;
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) nxt = DATA;
      end
      DATA: begin
        if (gnt_q) begin
          s1_rvalid = rvalid;
          rready    = s1_rready;
        end else begin
          s0_rvalid = rvalid;
          rready    = s0_rready;
        end
        if (rvalid && rready && rlast) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // latch AR, count beats, flag burst-length mismatches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q    <= '0;
      gnt_q   <= 1'b0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      if (arb_en && |req) begin
        gnt_q <= gnt_idx;
        if (gnt_idx)
          ar_q <= '{s1_arid, s1_araddr, s1_arlen,
                    s1_arsize, s1_arburst};
        else
          ar_q <= '{s0_arid, s0_araddr, s0_arlen,
                    s0_arsize, s0_arburst};
      end
      if (state == ADDR && arready) cnt <= '0;
      if (r_hs) begin
        cnt <= cnt + 1'b1;
        if ((rlast && cnt != ar_q.len) ||
            (!rlast && cnt == ar_q.len))
          len_err <= 1'b1;
      end
    end
  end

endmodule
